l2_evict_buffer: RTL
====================

# l2_evict_buffer

Eviction write buffer between the L2 cache controller and physical memory. It accepts dirty 256-bit lines evicted by L2, holds them in a small in-order FIFO, and writes them back to physical memory when the memory port is otherwise idle. It also carries L2 line-fill reads to physical memory, and serves those reads directly from the buffer when the requested line is still waiting for write-back.

## Interface
- DEPTH, 2: number of line entries; power of two, ≥2.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_ewb_buff  in  1  push request from L2.
- ewb_waddress  in  16  byte address of the evicted line; bits [4:0] ignored.
- ewb_wdata  in  256  evicted line data.
- ewb_empty  out  1  no valid entries.
- ewb_full  out  1  DEPTH valid entries.
- ewb_ready  out  1  memory port is not draining; L2 may issue a read.
- l2_pmem_read  in  1  L2 line-fill read request; held until l2_pmem_resp.
- l2_pmem_address  in  16  read address; bits [4:0] ignored.
- l2_pmem_rdata  out  256  fill data; valid while l2_pmem_resp=1.
- l2_pmem_resp  out  1  read complete; one-cycle pulse.
- pmem_address  out  16  physical memory address, always line aligned ([4:0]=0).
- pmem_wdata  out  256  write-back data.
- pmem_rdata  in  256  read data from physical memory.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_resp  in  1  physical access complete.

## Operation
- **Storage:** circular FIFO of DEPTH entries, each holding a tag (address bits [15:5]) and 256-bit data. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. A count register of log2(DEPTH)+1 bits tracks occupancy.
- **Push:**
  - When ld_ewb_buff=1 and the buffer is not full, write the entry at the tail and increment the tail.
  - When the buffer is full, drop the push; no state changes.
  - Pushing a tag that is already buffered appends a new entry; duplicate tags are legal.
- **Forward match:**
  - A match is a valid entry whose tag equals l2_pmem_address[15:5].
  - With multiple matches, the youngest entry (closest to the tail) supplies data.
  - A push in the current cycle is not visible to the match compare until the next cycle.
- **State machine** (states IDLE, READ, FWD, DRAIN):
  - IDLE, l2_pmem_read=1 and a match: go to FWD, latching the matched entry's data.
  - IDLE, l2_pmem_read=1 and no match: go to READ.
  - IDLE, no read and buffer not empty: go to DRAIN. A read request always has priority over draining.
  - READ: pmem_read=1 and pmem_address={l2_pmem_address[15:5],5'b0}. On pmem_resp, drive l2_pmem_resp=1 and l2_pmem_rdata=pmem_rdata combinationally, then go to IDLE.
  - FWD: l2_pmem_resp=1 with the latched data; go to IDLE. No physical access occurs.
  - DRAIN: pmem_write=1, with pmem_address={head tag,5'b0} and pmem_wdata=head data. On pmem_resp, pop the head (increment head) and go to IDLE. A drain is never aborted once started.
- **Status outputs:**
  - ewb_ready=1 in IDLE, READ and FWD; 0 in DRAIN.
  - ewb_empty=(count==0); ewb_full=(count==DEPTH).
- **Simultaneous push and pop:** both take effect in the same cycle and count is unchanged. When full, a push in the pop cycle is still dropped, because full is evaluated on the pre-pop count.
- **Idle outputs:** pmem_address is 0 in IDLE and FWD; pmem_read and pmem_write are never both 1.

## Timing
- **Reset:** state=IDLE, head=tail=count=0. Outputs after reset: ewb_empty=1, ewb_full=0, ewb_ready=1, l2_pmem_resp=0, l2_pmem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - Reset asserted mid-READ or mid-DRAIN drops the strobes in the next cycle and discards all buffered entries.
- **Push latency:** an entry pushed at edge N is reflected in ewb_empty, ewb_full and match at cycle N+1. The earliest DRAIN entry is edge N+1.
- **Forward read:** request seen in IDLE at cycle C; FWD in cycle C+1 with l2_pmem_resp=1. Total latency is 1 cycle.
- **Missed read:** pmem_read asserts in cycle C+1. l2_pmem_resp pulses in the same cycle as pmem_resp.
- **Drain:** pmem_write asserts the cycle after IDLE with a non-empty buffer and no read. The pop is visible at the edge following pmem_resp.
- **Read arriving during DRAIN:** the read waits; it is accepted in the IDLE cycle after the drain completes.

## Test plan
- **Forward hit:** reset; push addr 0x1234 with data D1; read 0x1220 at the next cycle → FWD, l2_pmem_resp=1 with data D1 one cycle later; pmem_read stays 0.
- **Drain order:** push 0x0100/A then 0x0200/B, no reads → pmem_write at 0x0100 with A, then 0x0200 with B; ewb_empty=1 after the second pmem_resp; ewb_ready=0 during each write.
- **Read priority:** one buffered entry, read 0x0400 asserted in the same cycle as the IDLE decision → READ first (pmem_read, addr 0x0400), then DRAIN.
- **Full and push-during-pop:** DEPTH=2; push 3 lines → the third is dropped and ewb_full=1. Push again in the pop cycle → dropped, count=1 after. Push one cycle later → accepted, count=2.
- **Duplicate tags:** push 0x0800/X then 0x0800/Y; read 0x0800 → returns Y; drain writes X then Y in order.
- **Reset mid-drain:** assert reset while pmem_write=1 → next cycle pmem_write=0, ewb_empty=1, state=IDLE.

Source files
------------

// File: rtl/l2_evict_buffer_if.sv
// Bus bundle between L2, the eviction write buffer and physical memory.
// The slave modport is the buffer's view; master is the view of the
// surrounding L2 controller and memory.
interface l2_evict_buffer_if;
  // L2 push side
  logic         ld_ewb_buff;
  logic [15:0]  ewb_waddress;
  logic [255:0] ewb_wdata;
  logic         ewb_empty;
  logic         ewb_full;
  logic         ewb_ready;
  // L2 line-fill read side
  logic         l2_pmem_read;
  logic [15:0]  l2_pmem_address;
  logic [255:0] l2_pmem_rdata;
  logic         l2_pmem_resp;
  // Physical memory side
  logic [15:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;

  modport slave (
    input  ld_ewb_buff, ewb_waddress, ewb_wdata,
    input  l2_pmem_read, l2_pmem_address,
    input  pmem_rdata, pmem_resp,
    output ewb_empty, ewb_full, ewb_ready,
    output l2_pmem_rdata, l2_pmem_resp,
    output pmem_address, pmem_wdata, pmem_read, pmem_write
  );

  modport master (
    output ld_ewb_buff, ewb_waddress, ewb_wdata,
    output l2_pmem_read, l2_pmem_address,
    output pmem_rdata, pmem_resp,
    input  ewb_empty, ewb_full, ewb_ready,
    input  l2_pmem_rdata, l2_pmem_resp,
    input  pmem_address, pmem_wdata, pmem_read, pmem_write
  );
endinterface

// File: rtl/l2_evict_buffer.sv
// L2 eviction write buffer: in-order FIFO of dirty lines that drains to
// physical memory when the port is idle, passes L2 fill reads through,
// and forwards fill reads straight from the buffer on a tag hit.
module l2_evict_buffer #(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  l2_evict_buffer_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FWD   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [10:0]     tag_q  [DEPTH];
  logic [255:0]    data_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic [255:0]    fwd_q, fwd_d;

  logic            push_s, pop_s, hit_s;
  logic [255:0]    hit_data_s;
  logic [PW-1:0]   idx_s;

  // Full is judged on the pre-pop count, so a push in the pop cycle of a
  // full buffer is dropped.
  assign push_s = bus.ld_ewb_buff & (count_q != CW'(DEPTH));
  assign pop_s  = (state_q == DRAIN) & bus.pmem_resp;

  // Tag match against valid entries, walked oldest to youngest so the
  // youngest duplicate wins.
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = 256'd0;
    idx_s      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_q + PW'(i);
      if ((CW'(i) < count_q) && (tag_q[idx_s] == bus.l2_pmem_address[15:5])) begin
        hit_s      = 1'b1;
        hit_data_s = data_q[idx_s];
      end else begin
        hit_s      = hit_s;
        hit_data_s = hit_data_s;
      end
    end
  end

  // Entry storage; validity is tracked by head/count so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      tag_q[tail_q]  <= bus.ewb_waddress[15:5];
      data_q[tail_q] <= bus.ewb_wdata;
    end
  end

  // FIFO pointers, occupancy, FSM state and forwarded-data latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      fwd_q   <= 256'd0;
    end else begin
      if (push_s) tail_q <= tail_q + PW'(1);
      if (pop_s)  head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push_s) - CW'(pop_s);
      state_q <= state_d;
      fwd_q   <= fwd_d;
    end
  end

  // Next-state and port outputs; a pending read always beats a drain.
  always_comb begin
    state_d           = state_q;
    fwd_d             = fwd_q;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_address  = 16'd0;
    bus.pmem_wdata    = 256'd0;
    bus.l2_pmem_resp  = 1'b0;
    bus.l2_pmem_rdata = 256'd0;
    bus.ewb_ready     = (state_q != DRAIN);
    bus.ewb_empty     = (count_q == CW'(0));
    bus.ewb_full      = (count_q == CW'(DEPTH));
    case (state_q)
      IDLE: begin
        if (bus.l2_pmem_read) begin
          if (hit_s) begin
            state_d = FWD;
            fwd_d   = hit_data_s;
          end else begin
            state_d = READ;
          end
        end else if (count_q != CW'(0)) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {bus.l2_pmem_address[15:5], 5'b00000};
        if (bus.pmem_resp) begin
          bus.l2_pmem_resp  = 1'b1;
          bus.l2_pmem_rdata = bus.pmem_rdata;
          state_d           = IDLE;
        end else begin
          state_d = READ;
        end
      end
      FWD: begin
        bus.l2_pmem_resp  = 1'b1;
        bus.l2_pmem_rdata = fwd_q;
        state_d           = IDLE;
      end
      DRAIN: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_q[head_q], 5'b00000};
        bus.pmem_wdata   = data_q[head_q];
        if (bus.pmem_resp) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
